md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multi-cycle multiply/divide unit in the E stage, beside the single-cycle ALU.
//  The ALU returns its result in the same cycle. md_unit instead accepts a start
//  request, holds busy high for a fixed latency, then commits its result to the
//  architectural HI/LO registers.
//  The hazard/stall unit reads busy. The M-stage MFHI/MFLO path reads hi/lo.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk     in   1   system clock
//  reset   in   1   synchronous, active-high reset
//  start   in   1   request valid this cycle
//  mdOp    in   3   operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO (`MD* codes)
//  srcA    in   32  operand A (rs); the data value for MTHI/MTLO
//  srcB    in   32  operand B (rt)
//  busy    out  1   multi-cycle operation in flight
//  hi      out  32  architectural HI register
//  lo      out  32  architectural LO register
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset values: busy=0, hi=0, lo=0, counter=0, pending regs=0.
//  - Reset dominates start, and reset mid-operation discards the pending result.
//  - Accept rule: a start is accepted only at a rising edge where start=1 && busy=0.
//    start while busy=1 is ignored, whatever the op, including MTHI/MTLO.
//    The stall unit ORs start into its stall term. md_unit never queues requests.
//  - MTHI/MTLO on accept: hi (or lo) <= srcA at that edge. busy stays 0 (latency 1).
//  - MULT/MULTU/DIV/DIVU on accept:
//    * pending {phi,plo} is computed from srcA/srcB and captured at that edge.
//    * counter loads N (MULT_CYCLES or DIV_CYCLES) and busy goes to 1.
//    * Each later edge decrements counter.
//    * At the edge where counter==1: hi<=phi, lo<=plo, busy<=0, counter<=0.
//    * Timing: start accepted at edge t0 gives busy=1 for exactly N cycles; new
//      hi/lo and busy=0 are visible together from edge t0+N.
//    * hi/lo keep their old values throughout the busy window.
//  - Arithmetic:
//    * MULT:  {phi,plo} = $signed(srcA) * $signed(srcB), full 64 bits.
//    * MULTU: {phi,plo} = unsigned 64-bit product.
//    * DIV:   plo = signed quotient, truncated toward zero; phi = remainder, sign
//      of the dividend.
//    * DIV 0x80000000 / -1 gives plo=0x80000000, phi=0 (no trap).
//    * DIVU:  unsigned quotient/remainder.
//    * Divide by zero: accepted, busy runs the full DIV_CYCLES, hi/lo unchanged.
//  - Unknown mdOp with start=1: no state change, busy stays 0.
//  - No flush input. Exceptions are out of scope for this pipeline revision.
// STRUCTURE
//  - Operation codes MDMULT, MDMULTU, MDDIV, MDDIVU, MDMTHI, MDMTLO (3-bit) go
//    in the shared param.v header alongside the ALU op codes.
//  - Single module with no sub-module. Internals: a counter sized with $clog2
//    of the larger latency, the phi/plo pending registers, and hi/lo.
// TESTING
//  1. MULT srcA=0xFFFFFFFD (-3), srcB=5 -> busy=1 for 5 cycles, then
//     hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
//  2. MULTU 0xFFFFFFFF x 2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
//  3. DIV -7/2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU 7/2 -> lo=3, hi=1.
//  4. hi=0x11, lo=0x22, then DIV x/0 -> busy=1 for 10 cycles; hi=0x11, lo=0x22.
//  5. Start MULT, then MTHI 0xABCD at busy cycle 2 -> ignored (hi gets the
//     product). MTHI 0xABCD when idle -> hi=0xABCD next cycle, busy never rises.
//  6. Start DIV, assert reset in busy cycle 3 -> next cycle busy=0, hi=lo=0.
//     No late commit ever appears over 15 idle cycles.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared operation codes for the E-stage multiply/divide unit.
// Codes 6 and 7 are unused and are ignored when start is asserted.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MDMULT  = 3'd0,
    MDMULTU = 3'd1,
    MDDIV   = 3'd2,
    MDDIVU  = 3'd3,
    MDMTHI  = 3'd4,
    MDMTLO  = 3'd5
  } md_op_e;

  localparam int MD_WORD_W = 32;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit: computes a pending {phi,plo} on accept,
// holds busy for a fixed latency, then commits the result to HI/LO.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      phi_q, phi_d, plo_q, plo_d;
  logic             commit_q, commit_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [63:0]        prod_s, prod_u;
  logic [31:0]        quot, rem;
  logic signed [31:0] a_s, b_s;
  logic               div_by_zero;

  assign a_s         = srcA;
  assign b_s         = srcB;
  assign div_by_zero = (srcB == 32'd0);
  assign prod_s      = 64'(a_s) * 64'(b_s);
  assign prod_u      = 64'(srcA) * 64'(srcB);

  // The most-negative / -1 case overflows the signed quotient; it is pinned to
  // the wrapped result so the divider never produces X.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    quot = 32'd0;
    rem  = 32'd0;
    if (!div_by_zero) begin
      if (mdOp == MDDIV) begin
        if (srcA == 32'h8000_0000 && srcB == 32'hFFFF_FFFF) begin
          quot = 32'h8000_0000;
        end else begin
          quot = 32'(a_s / b_s);
          rem  = 32'(a_s % b_s);
        end
      end else begin
        quot = srcA / srcB;
        rem  = srcA % srcB;
      end
    end
  end

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    phi_d    = phi_q;
    plo_d    = plo_q;
    commit_d = commit_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;

    if (busy_q) begin
      // Requests arriving while busy are dropped, never queued.
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (commit_q) begin
          hi_d = phi_q;
          lo_d = plo_q;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (start) begin
      case (mdOp)
        MDMTHI: hi_d = srcA;
        MDMTLO: lo_d = srcA;
        MDMULT, MDMULTU: begin
          phi_d    = (mdOp == MDMULT) ? prod_s[63:32] : prod_u[63:32];
          plo_d    = (mdOp == MDMULT) ? prod_s[31:0]  : prod_u[31:0];
          commit_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = CNT_W'(MULT_CYCLES);
        end
        MDDIV, MDDIVU: begin
          // Divide by zero still occupies the full latency but leaves HI/LO alone.
          phi_d    = rem;
          plo_d    = quot;
          commit_d = !div_by_zero;
          busy_d   = 1'b1;
          cnt_d    = CNT_W'(DIV_CYCLES);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      phi_q    <= '0;
      plo_q    <= '0;
      commit_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      phi_q    <= phi_d;
      plo_q    <= plo_d;
      commit_q <= commit_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases followed by random traffic,
// every cycle compared against a remaining-cycles model using plain arithmetic.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  mdOp;
  logic [31:0] srcA, srcB;
  logic        busy;
  logic [31:0] hi, lo;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_commit;
  int          m_left;

  md_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdOp  (mdOp),
    .srcA  (srcA),
    .srcB  (srcB),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] ph, output logic [31:0] pl);
    longint      sp;
    logic [63:0] up;
    if (sgn) begin
      sp = longint'(signed'(a)) * longint'(signed'(b));
      up = sp;
    end else begin
      up = {32'd0, a} * {32'd0, b};
    end
    ph = up[63:32];
    pl = up[31:0];
  endtask

  // Quotient from magnitudes with the sign applied afterwards; remainder is a - q*b.
  task automatic model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, ma, mb, qq, rr;
    if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    qq = ma / mb;
    if ((sa < 0) != (sb < 0)) qq = -qq;
    rr = sa - qq * sb;
    q  = qq[31:0];
    r  = rr[31:0];
  endtask

  task automatic model_edge();
    logic [31:0] x, y;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_commit = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_commit) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (start) begin
      case (mdOp)
        3'd4: m_hi = srcA;
        3'd5: m_lo = srcA;
        3'd0, 3'd1: begin
          model_mul(mdOp == 3'd0, srcA, srcB, x, y);
          m_phi = x; m_plo = y; m_commit = 1'b1; m_left = N_MULT;
        end
        3'd2, 3'd3: begin
          m_left   = N_DIV;
          m_commit = (srcB != 0);
          if (srcB != 0) begin
            model_div(mdOp == 3'd2, srcA, srcB, x, y);
            m_plo = x; m_phi = y;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic st, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    reset = rst; start = st; mdOp = op; srcA = a; srcB = b;
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_busy"}, 32'(busy), 32'(m_left > 0));
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; mdOp = 3'd0; srcA = '0; srcB = '0;
    m_hi = 32'hDEAD_BEEF; m_lo = 32'hDEAD_BEEF; m_phi = '0; m_plo = '0;
    m_commit = 1'b0; m_left = 0;

    // Reset, with start held high to show reset dominates.
    step("rst", 1'b1, 1'b1, MDMTHI, 32'h1234_5678, 32'd0);
    step("rst", 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    check("rst_hi_zero", hi, 32'd0);
    check("rst_busy_zero", 32'(busy), 32'd0);

    // MULT -3 * 5
    step("mult", 1'b0, 1'b1, MDMULT, 32'hFFFF_FFFD, 32'd5);
    for (int i = 0; i < N_MULT - 1; i++) begin
      idle("mult_wait", 1);
      check("mult_busy_held", 32'(busy), 32'd1);
      check("mult_hi_held", hi, 32'd0);
    end
    idle("mult_done", 1);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    check("mult_busy_low", 32'(busy), 32'd0);

    // MULTU 0xFFFFFFFF * 2
    step("multu", 1'b0, 1'b1, MDMULTU, 32'hFFFF_FFFF, 32'd2);
    idle("multu_wait", N_MULT);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    // DIV -7 / 2, then DIVU 7 / 2
    step("div", 1'b0, 1'b1, MDDIV, 32'hFFFF_FFF9, 32'd2);
    idle("div_wait", N_DIV - 1);
    check("div_busy_last", 32'(busy), 32'd1);
    idle("div_done", 1);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    step("divu", 1'b0, 1'b1, MDDIVU, 32'd7, 32'd2);
    idle("divu_wait", N_DIV);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    // Signed overflow divide
    step("divov", 1'b0, 1'b1, MDDIV, 32'h8000_0000, 32'hFFFF_FFFF);
    idle("divov_wait", N_DIV);
    check("divov_lo", lo, 32'h8000_0000);
    check("divov_hi", hi, 32'd0);

    // Divide by zero leaves HI/LO untouched
    step("mthi11", 1'b0, 1'b1, MDMTHI, 32'h11, 32'd0);
    step("mtlo22", 1'b0, 1'b1, MDMTLO, 32'h22, 32'd0);
    step("div0", 1'b0, 1'b1, MDDIV, 32'd99, 32'd0);
    idle("div0_wait", N_DIV - 1);
    check("div0_busy_last", 32'(busy), 32'd1);
    idle("div0_done", 1);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);
    check("div0_busy_low", 32'(busy), 32'd0);

    // MTHI while busy is ignored; MTHI while idle lands in one cycle
    step("mult34", 1'b0, 1'b1, MDMULT, 32'd3, 32'd4);
    idle("mult34_c1", 1);
    step("mthi_busy", 1'b0, 1'b1, MDMTHI, 32'hABCD, 32'd0);
    idle("mult34_wait", N_MULT - 2);
    check("mthi_ignored_hi", hi, 32'd0);
    check("mthi_ignored_lo", lo, 32'd12);
    step("mthi_idle", 1'b0, 1'b1, MDMTHI, 32'hABCD, 32'd0);
    check("mthi_idle_hi", hi, 32'hABCD);
    check("mthi_idle_busy", 32'(busy), 32'd0);

    // Unknown opcode does nothing
    step("badop", 1'b0, 1'b1, 3'd6, 32'h5555, 32'd1);
    check("badop_busy", 32'(busy), 32'd0);
    check("badop_hi", hi, 32'hABCD);

    // Reset mid-divide discards the pending result
    step("divrst", 1'b0, 1'b1, MDDIV, 32'd100, 32'd7);
    idle("divrst_c", 2);
    step("divrst_rst", 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    check("divrst_busy", 32'(busy), 32'd0);
    check("divrst_hi", hi, 32'd0);
    check("divrst_lo", lo, 32'd0);
    for (int i = 0; i < 15; i++) begin
      idle("divrst_quiet", 1);
      check("no_late_commit", lo, 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0),
           3'($urandom_range(0, 7)), rand_word(), rand_word());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
